// File: rtl/uart_tx_frame.sv
// Frame-level UART transmitter: resend/ack one-shot codes plus a data FIFO,
// with configurable data width, oversample ratio, parity and stop bits.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  ACK_CODE    = 8'hAA,
  parameter logic [7:0]  RESEND_CODE = 8'hCC
) (
  input  logic                          uart_sampling_clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          ack,
  input  logic                          resend,
  input  logic                          USB_RTS,
  output logic                          USB_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DATA_BITS-1:0] ACK_WORD    = DATA_BITS'(ACK_CODE);
  localparam logic [DATA_BITS-1:0] RESEND_WORD = DATA_BITS'(RESEND_CODE);
  localparam logic [SMP_W-1:0]     SMP_LAST    = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]     DBIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]     SBIT_LAST   = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic                 PAR_ODD     = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SMP_W-1:0]     sample_q, sample_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ack_pend_q, ack_pend_d;
  logic                 resend_pend_q, resend_pend_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 tx_ready_q, tx_ready_d;

  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 sample_last;
  logic                 frame_end;
  logic                 src_avail;
  logic                 load;
  logic                 sel_resend;
  logic                 sel_ack;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] load_word;

  // Load decision: a new frame may start from idle or on the very last cycle of the final stop bit.
  always_comb begin
    sample_last = (sample_q == SMP_LAST);
    frame_end   = (state_q == S_STOP) && sample_last && (bit_q == SBIT_LAST);
    src_avail   = resend_pend_q || ack_pend_q || (count_q != '0);
    load        = ((state_q == S_IDLE) || frame_end) && !USB_RTS && src_avail;
    sel_resend  = resend_pend_q;
    sel_ack     = !resend_pend_q && ack_pend_q;
    pop         = load && !resend_pend_q && !ack_pend_q;
    push        = tx_valid && tx_ready_q;
    if (sel_resend) begin
      load_word = RESEND_WORD;
    end else if (sel_ack) begin
      load_word = ACK_WORD;
    end else begin
      load_word = mem_q[rd_ptr_q];
    end
  end

  // FSM state register
  always_ff @(posedge uart_sampling_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load) state_d = S_START;
      end
      S_START: begin
        if (sample_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (sample_last && (bit_q == DBIT_LAST)) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (frame_end) state_d = load ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, computed from the next state so the registered line lines up with the state
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit timing, shift register, pending flags and FIFO bookkeeping
  always_comb begin
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    if (load) begin
      sample_d = '0;
      bit_d    = '0;
      shift_d  = load_word;
      par_d    = (^load_word) ^ PAR_ODD;
    end else if (state_q != S_IDLE) begin
      sample_d = sample_last ? '0 : sample_q + SMP_W'(1);
      if (sample_last) begin
        case (state_q)
          S_DATA: begin
            shift_d = shift_q >> 1;
            bit_d   = (bit_q == DBIT_LAST) ? '0 : bit_q + BIT_W'(1);
          end
          S_STOP:  bit_d = bit_q + BIT_W'(1);
          default: bit_d = '0;
        endcase
      end
    end

    // A new pulse wins over the clear caused by loading the same source.
    ack_pend_d    = ack    || (ack_pend_q    && !(load && sel_ack));
    resend_pend_d = resend || (resend_pend_q && !(load && sel_resend));

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    tx_ready_d = (count_d < CNT_FULL);
  end

  // Datapath and output registers
  always_ff @(posedge uart_sampling_clk) begin
    if (rst) begin
      sample_q      <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      ack_pend_q    <= 1'b0;
      resend_pend_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_ready_q    <= 1'b1;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      ack_pend_q    <= ack_pend_d;
      resend_pend_q <= resend_pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_ready_q    <= tx_ready_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge uart_sampling_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign USB_TX     = tx_q;
  assign busy       = busy_q;
  assign tx_ready   = tx_ready_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: default-parameter instance plus a 7-bit/odd/2-stop/x4 instance,
// checked against a frame-level model of source priority and line bit sequence.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ack = 1'b0;
  logic       resend = 1'b0;
  logic       rts = 1'b0;
  logic       tx_ready, usb_tx, busy;
  logic [2:0] fifo_count;

  logic [6:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       resend2 = 1'b0;
  logic       rts2 = 1'b0;
  logic       tx_ready2, usb_tx2, busy2;
  logic [2:0] fifo_count2;

  uart_tx_frame dut (
    .uart_sampling_clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ack(ack), .resend(resend), .USB_RTS(rts),
    .USB_TX(usb_tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2), .PARITY(2)) dut2 (
    .uart_sampling_clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .ack(ack2), .resend(resend2), .USB_RTS(rts2),
    .USB_TX(usb_tx2), .busy(busy2), .fifo_count(fifo_count2)
  );

  int vectors = 0;
  int errors  = 0;

  // Frame-level reference model for the default instance
  logic [8:0] m_fifo[$];
  bit         m_ack = 1'b0;
  bit         m_resend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_has();
    return m_resend || m_ack || (m_fifo.size() != 0);
  endfunction

  function automatic logic [8:0] m_pick();
    if (m_resend) begin
      m_resend = 1'b0;
      return 9'h0CC;
    end
    if (m_ack) begin
      m_ack = 1'b0;
      return 9'h0AA;
    end
    return m_fifo.pop_front();
  endfunction

  // Expected line level for bit slot idx of a frame carrying w
  function automatic logic exp_bit(input logic [8:0] w, input int idx, input int dbits, input int par);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= dbits) return w[idx-1];
    if (par != 0 && idx == dbits + 1) begin
      p = 1'b0;
      for (int k = 0; k < dbits; k++) p = p ^ w[k];
      return p ^ (par == 2);
    end
    return 1'b1;
  endfunction

  task automatic push(input int inst, input logic [8:0] w);
    @(negedge clk);
    if (inst == 0) begin
      tx_data = w[7:0];
      tx_valid = 1'b1;
      if (m_fifo.size() < 4) m_fifo.push_back(w);
    end else begin
      tx_data2 = w[6:0];
      tx_valid2 = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_valid2 = 1'b0;
  endtask

  task automatic wait_start(input int inst, input int budget);
    int n = 0;
    while (((inst == 0) ? busy : busy2) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_within_budget", 32'((inst == 0) ? busy : busy2), 32'd1);
  endtask

  // Called on the negedge of the first start-bit cycle; returns on the negedge after the frame.
  // pulse_kind 1 = ack pulse, 2 = raise RTS, at frame cycle pulse_at.
  task automatic check_frame(input int inst, input logic [8:0] w, input int dbits, input int ovs,
                             input int par, input int stopb, input int pulse_at, input int pulse_kind);
    int  len = (1 + dbits + ((par != 0) ? 1 : 0) + stopb) * ovs;
    bit  more;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("tx_w%0h_c%0d", w, i), 32'((inst == 0) ? usb_tx : usb_tx2),
          32'(exp_bit(w, i / ovs, dbits, par)));
      chk($sformatf("busy_w%0h_c%0d", w, i), 32'((inst == 0) ? busy : busy2), 32'd1);
      ack = 1'b0;
      if (i == pulse_at && pulse_kind == 1) begin
        ack = 1'b1;
        m_ack = 1'b1;
      end
      if (i == pulse_at && pulse_kind == 2) rts = 1'b1;
      @(negedge clk);
    end
    ack = 1'b0;
    more = (inst == 0) ? (m_has() && !rts) : 1'b0;
    chk($sformatf("busy_after_w%0h", w), 32'((inst == 0) ? busy : busy2), 32'(more));
  endtask

  initial begin
    logic [8:0] w;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(usb_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx2", 32'(usb_tx2), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(usb_tx), 32'd1);

    // Single resend frame
    resend = 1'b1;
    m_resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
    chk("resend_pend_idle", 32'(busy), 32'd0);
    wait_start(0, 4);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, -1, 0);
    repeat (5) @(negedge clk);

    // ack and resend in the same cycle: CC then AA back-to-back
    ack = 1'b1;
    resend = 1'b1;
    m_ack = 1'b1;
    m_resend = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    resend = 1'b0;
    wait_start(0, 4);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, -1, 0);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, -1, 0);
    repeat (5) @(negedge clk);

    // RTS held: fill the FIFO, one extra push is dropped
    rts = 1'b1;
    for (int k = 0; k < 5; k++) push(0, 9'($urandom_range(0, 255)));
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(tx_ready), 32'd0);
    chk("full_tx", 32'(usb_tx), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("rts_hold_tx", 32'(usb_tx), 32'd1);
    rts = 1'b0;
    wait_start(0, 4);
    chk("pop_count", 32'(fifo_count), 32'd3);
    chk("pop_ready", 32'(tx_ready), 32'd1);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, -1, 0);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, 30, 1);
    while (m_has()) begin
      w = m_pick();
      check_frame(0, w, 8, 16, 0, 1, -1, 0);
    end
    repeat (5) @(negedge clk);

    // RTS raised mid-frame: frame completes, queued frame waits, then starts one cycle after RTS falls
    rts = 1'b1;
    push(0, 9'($urandom_range(0, 255)));
    push(0, 9'($urandom_range(0, 255)));
    rts = 1'b0;
    wait_start(0, 4);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, 50, 2);
    for (int k = 0; k < 20; k++) begin
      chk("rts_wait_busy", 32'(busy), 32'd0);
      chk("rts_wait_tx", 32'(usb_tx), 32'd1);
      @(negedge clk);
    end
    rts = 1'b0;
    @(negedge clk);
    chk("rts_release_busy", 32'(busy), 32'd1);
    chk("rts_release_tx", 32'(usb_tx), 32'd0);
    w = m_pick();
    check_frame(0, w, 8, 16, 0, 1, -1, 0);

    // Second configuration: directed 7'h55 then a random word
    rts2 = 1'b1;
    push(1, 9'h055);
    @(negedge clk);
    rts2 = 1'b0;
    wait_start(1, 4);
    check_frame(1, 9'h055, 7, 4, 2, 2, -1, 0);
    w = 9'($urandom_range(0, 127));
    push(1, w);
    wait_start(1, 4);
    check_frame(1, w, 7, 4, 2, 2, -1, 0);

    // Reset mid-frame with ack pending and two words queued
    rts = 1'b1;
    for (int k = 0; k < 3; k++) push(0, 9'($urandom_range(0, 255)));
    rts = 1'b0;
    wait_start(0, 4);
    w = m_pick();
    for (int i = 0; i < 69; i++) begin
      chk($sformatf("pre_rst_tx_c%0d", i), 32'(usb_tx), 32'(exp_bit(w, i / 16, 8, 0)));
      ack = (i == 5);
      if (i == 6) chk("pre_rst_count", 32'(fifo_count), 32'd2);
      @(negedge clk);
    end
    ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_fifo.delete();
    m_ack = 1'b0;
    chk("mid_rst_tx", 32'(usb_tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    for (int k = 0; k < 200; k++) begin
      chk("post_rst_idle", 32'({busy, usb_tx}), 32'b01);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised successor to the fixed ACK/RESEND UART transmitter. Serialises frames on USB_TX from three request sources:
- a one-shot resend code
- a one-shot ack code
- a FIFO of host-supplied data words

Frame format is configurable: data width, oversample ratio, parity and stop bits. USB_RTS flow control is applied at frame granularity. The block sits between protocol control logic and the USB-UART bridge pins, clocked by the UART sampling clock.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, uart_sampling_clk cycles per bit period (>=2).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 4, data FIFO entries (power of 2, >=2).
- ACK_CODE, 8'hAA, word sent for ack (truncated/zero-extended to DATA_BITS).
- RESEND_CODE, 8'hCC, word sent for resend (same width rule).

Ports:
- uart_sampling_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  FIFO write data.
- tx_valid  in  1  write request.
- tx_ready  out  1  FIFO can accept; high when fifo_count < FIFO_DEPTH.
- ack  in  1  single-cycle request to send ACK_CODE.
- resend  in  1  single-cycle request to send RESEND_CODE.
- USB_RTS  in  1  high = receiver not ready; no new frame may start.
- USB_TX  out  1  serial line, registered, idles high.
- busy  out  1  high while a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is synchronous. Next edge after rst high:
  - USB_TX = 1, busy = 0, fifo_count = 0, tx_ready = 1.
  - State IDLE; pending flags cleared.
  - Any frame in progress is abandoned; FIFO contents are discarded.
- Pending flags ack_pend and resend_pend:
  - Each is set on its input pulse and cleared when its frame is loaded.
  - A set in the same cycle as a clear leaves the flag set.
  - Repeated pulses while a flag is pending coalesce into one frame.
- FIFO write: push when tx_valid & tx_ready. No push when full. Order is preserved.
- Source priority at load: resend_pend > ack_pend > FIFO non-empty. The FIFO pops in the load cycle.
- Load condition: (state IDLE, or last cycle of the final stop bit) & ~USB_RTS & any source available.
- On load:
  - The shift register takes the word.
  - The parity bit is computed from the loaded word: XOR of its bits, inverted for PARITY=2.
  - State goes to START.
  - USB_TX = 0 from the next cycle.
- Frame on line: start bit (0), then DATA_BITS LSB first, then parity bit if PARITY != 0, then STOP_BITS ones.
  - Every bit is held exactly OVERSAMPLE cycles.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE or START.
  - sample_cnt runs 0..OVERSAMPLE-1; the bit advances when it reaches OVERSAMPLE-1.
  - bit_cnt counts data bits 0..DATA_BITS-1, then stop bits 0..STOP_BITS-1.
- Frame length L = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * OVERSAMPLE cycles.
  - Back-to-back frames have no idle gap between them.
- USB_RTS is evaluated only at load. Asserting it mid-frame does not alter the frame in progress.
- busy = (state != IDLE), registered. It stays high across back-to-back frames.
- USB_TX is high in IDLE.

Test Plan:
1. Default params, RTS low, one resend pulse:
   - USB_TX = 0 for 16 cycles, then bits 0,0,1,1,0,0,1,1 (16 cycles each), then 1 for 16 cycles.
   - busy high for exactly 160 cycles.
2. ack and resend pulsed in the same cycle -> an 0xCC frame then an 0xAA frame, 320 contiguous busy cycles, no idle bit between them.
3. RTS high, push 0x01, 0x02, 0x03, 0x04:
   - fifo_count = 4, tx_ready = 0, USB_TX stays 1.
   - Drop RTS -> frames 0x01, 0x02 sent in order.
   - An ack pulse during frame 0x02 -> 0xAA is sent before 0x03.
4. DATA_BITS=7, PARITY=2, STOP_BITS=2, OVERSAMPLE=4, push 7'h55 -> start, 1,0,1,0,1,0,1, parity 1, then 1,1; frame length 44 cycles.
5. RTS raised at cycle 50 of a frame -> the frame completes unchanged. A queued frame waits until RTS falls, then starts one cycle later.
6. rst for one cycle during data bit 3 with ack pending and FIFO count 2:
   - Next cycle: USB_TX = 1, busy = 0, fifo_count = 0, no ack frame sent afterward.
